// File: rtl/rrf_commit_tracker_pkg.sv
// Shared rename-file constants; the entry allocator uses the same values.
package rrf_commit_tracker_pkg;
    localparam int unsigned RRF_NUM_C = 64;
    localparam int unsigned RRF_SEL_C = 6;
    localparam int unsigned ARF_SEL_C = 5;
endpackage

// File: rtl/rrf_finish_bits.sv
// Per-entry finished flags: allocate-clear beats set, set beats commit-clear.
module rrf_finish_bits
    import rrf_commit_tracker_pkg::*;
#(
    parameter int unsigned RRF_NUM = RRF_NUM_C,
    parameter int unsigned RRF_SEL = RRF_SEL_C
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               alloc_valid_i,
    input  logic [RRF_SEL-1:0] alloc_tag_i,
    input  logic               set0_valid_i,
    input  logic [RRF_SEL-1:0] set0_tag_i,
    input  logic               set1_valid_i,
    input  logic [RRF_SEL-1:0] set1_tag_i,
    input  logic               clr0_valid_i,
    input  logic [RRF_SEL-1:0] clr0_tag_i,
    input  logic               clr1_valid_i,
    input  logic [RRF_SEL-1:0] clr1_tag_i,
    output logic [RRF_NUM-1:0] finished_o
);
    logic [RRF_NUM-1:0] finished_q;
    logic [RRF_NUM-1:0] finished_d;

    // Later assignments win: a tag reused by the allocator in its commit cycle
    // must come out unfinished.
    always_comb begin
        finished_d = finished_q;
        if (clr0_valid_i) finished_d[clr0_tag_i] = 1'b0;
        if (clr1_valid_i) finished_d[clr1_tag_i] = 1'b0;
        if (set0_valid_i) finished_d[set0_tag_i] = 1'b1;
        if (set1_valid_i) finished_d[set1_tag_i] = 1'b1;
        if (alloc_valid_i) finished_d[alloc_tag_i] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) finished_q <= '0;
        else         finished_q <= finished_d;
    end

    assign finished_o = finished_q;
endmodule

// File: rtl/rrf_commit_tracker.sv
// In-order retire of rename entries, up to two per cycle, with ARF write-back enables.
module rrf_commit_tracker
    import rrf_commit_tracker_pkg::*;
#(
    parameter int unsigned RRF_NUM = RRF_NUM_C,
    parameter int unsigned RRF_SEL = RRF_SEL_C,
    parameter int unsigned ARF_SEL = ARF_SEL_C
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               alloc_valid_i,
    input  logic [RRF_SEL-1:0] alloc_tag_i,
    input  logic               alloc_dstval_i,
    input  logic [ARF_SEL-1:0] alloc_dst_i,
    input  logic               fin0_valid_i,
    input  logic [RRF_SEL-1:0] fin0_tag_i,
    input  logic               fin1_valid_i,
    input  logic [RRF_SEL-1:0] fin1_tag_i,
    output logic [1:0]         com_inst_num_o,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic [RRF_SEL-1:0] com_tag1_o,
    output logic [RRF_SEL-1:0] com_tag2_o,
    output logic               arfwe1_o,
    output logic               arfwe2_o,
    output logic [ARF_SEL-1:0] dst_arf1_o,
    output logic [ARF_SEL-1:0] dst_arf2_o,
    output logic [RRF_SEL:0]   inflight_o,
    output logic               empty_o
);
    logic [RRF_SEL-1:0] comptr_q;
    logic [RRF_SEL:0]   inflight_q;
    logic [ARF_SEL-1:0] dst_q [RRF_NUM];
    logic [RRF_NUM-1:0] dstval_q;
    logic [RRF_NUM-1:0] finished;
    logic               c1, c2;
    logic [RRF_SEL-1:0] tag1, tag2;
    logic [RRF_SEL-1:0] fin0_off, fin1_off;

    assign tag1 = comptr_q;
    assign tag2 = comptr_q + RRF_SEL'(1);

    rrf_finish_bits #(
        .RRF_NUM (RRF_NUM),
        .RRF_SEL (RRF_SEL)
    ) u_finish_bits (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_tag_i   (alloc_tag_i),
        .set0_valid_i  (fin0_valid_i),
        .set0_tag_i    (fin0_tag_i),
        .set1_valid_i  (fin1_valid_i),
        .set1_tag_i    (fin1_tag_i),
        .clr0_valid_i  (c1),
        .clr0_tag_i    (tag1),
        .clr1_valid_i  (c2),
        .clr1_tag_i    (tag2),
        .finished_o    (finished)
    );

    always_ff @(posedge clk_i) begin
        if (alloc_valid_i) begin
            dst_q[alloc_tag_i]    <= alloc_dst_i;
            dstval_q[alloc_tag_i] <= alloc_dstval_i;
        end
    end

    always_comb begin
        c1 = (inflight_q != '0) && finished[tag1];
        c2 = c1 && (inflight_q >= (RRF_SEL+1)'(2)) && finished[tag2];
    end

    assign com_inst_num_o = c2 ? 2'd2 : {1'b0, c1};
    assign com_tag1_o     = tag1;
    assign com_tag2_o     = tag2;
    assign arfwe1_o       = c1 && dstval_q[tag1];
    assign arfwe2_o       = c2 && dstval_q[tag2];
    assign dst_arf1_o     = dst_q[tag1];
    assign dst_arf2_o     = dst_q[tag2];
    assign comptr_o       = comptr_q;
    assign inflight_o     = inflight_q;
    assign empty_o        = (inflight_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            comptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            comptr_q   <= comptr_q + RRF_SEL'(com_inst_num_o);
            inflight_q <= inflight_q + (RRF_SEL+1)'(alloc_valid_i)
                                     - (RRF_SEL+1)'(com_inst_num_o);
        end
    end

    // A finishing tag must lie in the window [comptr, comptr+inflight).
    assign fin0_off = fin0_tag_i - comptr_q;
    assign fin1_off = fin1_tag_i - comptr_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!fin0_valid_i || ({1'b0, fin0_off} < inflight_q))
                else $error("finish on unallocated tag %0d", fin0_tag_i);
            assert (!fin1_valid_i || ({1'b0, fin1_off} < inflight_q))
                else $error("finish on unallocated tag %0d", fin1_tag_i);
        end
    end
endmodule

// File: tb/tb_rrf_commit_tracker.sv
// Directed and allocator-model-driven checks of rrf_commit_tracker.
module tb_rrf_commit_tracker;
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       alloc_valid_i;
    logic [5:0] alloc_tag_i;
    logic       alloc_dstval_i;
    logic [4:0] alloc_dst_i;
    logic       fin0_valid_i, fin1_valid_i;
    logic [5:0] fin0_tag_i, fin1_tag_i;
    logic [1:0] com_inst_num_o;
    logic [5:0] comptr_o, com_tag1_o, com_tag2_o;
    logic       arfwe1_o, arfwe2_o;
    logic [4:0] dst_arf1_o, dst_arf2_o;
    logic [6:0] inflight_o;
    logic       empty_o;

    int checks = 0;
    int failures = 0;

    rrf_commit_tracker dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_tag_i    (alloc_tag_i),
        .alloc_dstval_i (alloc_dstval_i),
        .alloc_dst_i    (alloc_dst_i),
        .fin0_valid_i   (fin0_valid_i),
        .fin0_tag_i     (fin0_tag_i),
        .fin1_valid_i   (fin1_valid_i),
        .fin1_tag_i     (fin1_tag_i),
        .com_inst_num_o (com_inst_num_o),
        .comptr_o       (comptr_o),
        .com_tag1_o     (com_tag1_o),
        .com_tag2_o     (com_tag2_o),
        .arfwe1_o       (arfwe1_o),
        .arfwe2_o       (arfwe2_o),
        .dst_arf1_o     (dst_arf1_o),
        .dst_arf2_o     (dst_arf2_o),
        .inflight_o     (inflight_o),
        .empty_o        (empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_alloc(input logic v, input int tag, input int dst, input logic dv);
        alloc_valid_i  = v;
        alloc_tag_i    = 6'(tag);
        alloc_dst_i    = 5'(dst);
        alloc_dstval_i = dv;
    endtask

    task automatic set_fin(input logic v0, input int t0, input logic v1, input int t1);
        fin0_valid_i = v0;
        fin0_tag_i   = 6'(t0);
        fin1_valid_i = v1;
        fin1_tag_i   = 6'(t1);
    endtask

    typedef struct {
        logic [5:0] tag;
        logic [4:0] dst;
        logic       dv;
        logic       fin;
    } ent_t;

    ent_t       q[$];
    int         freenum;
    logic [5:0] rrfptr;

    initial begin
        set_alloc(0, 0, 0, 0);
        set_fin(0, 0, 0, 0);
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;

        chk("rst_comptr", 32'(comptr_o), 0);
        chk("rst_inflight", 32'(inflight_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_num", 32'(com_inst_num_o), 0);

        // In-order retire: finishes arrive 2,1,0
        set_alloc(1, 0, 5, 1); tick();
        set_alloc(1, 1, 6, 1); tick();
        set_alloc(1, 2, 0, 0); tick();
        set_alloc(0, 0, 0, 0);
        chk("ord_inflight3", 32'(inflight_o), 3);
        set_fin(1, 2, 0, 0); tick();
        chk("ord_wait_a", 32'(com_inst_num_o), 0);
        set_fin(1, 1, 0, 0); tick();
        chk("ord_wait_b", 32'(com_inst_num_o), 0);
        set_fin(1, 0, 0, 0); tick();
        set_fin(0, 0, 0, 0);
        chk("ord_num2", 32'(com_inst_num_o), 2);
        chk("ord_we1", 32'(arfwe1_o), 1);
        chk("ord_dst1", 32'(dst_arf1_o), 5);
        chk("ord_we2", 32'(arfwe2_o), 1);
        chk("ord_dst2", 32'(dst_arf2_o), 6);
        tick();
        chk("ord_num1", 32'(com_inst_num_o), 1);
        chk("ord_tag1", 32'(com_tag1_o), 2);
        chk("ord_we1_off", 32'(arfwe1_o), 0);
        tick();
        chk("ord_comptr3", 32'(comptr_o), 3);
        chk("ord_empty", 32'(empty_o), 1);
        chk("ord_num0", 32'(com_inst_num_o), 0);

        // Advance comptr to 62 by streaming tags 3..61
        for (int t = 3; t <= 61; t++) begin
            set_alloc(1, t, t, 1);
            set_fin(t > 3, t - 1, 0, 0);
            tick();
        end
        set_alloc(0, 0, 0, 0);
        set_fin(1, 61, 0, 0);
        tick();
        set_fin(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            if (empty_o) break;
            tick();
        end
        chk("wrap_comptr62", 32'(comptr_o), 62);
        chk("wrap_empty", 32'(empty_o), 1);

        set_alloc(1, 62, 1, 1); tick();
        set_alloc(1, 63, 2, 0); tick();
        set_alloc(1, 0, 3, 1); tick();
        set_alloc(0, 0, 0, 0);
        set_fin(1, 62, 1, 63); tick();
        set_fin(1, 0, 0, 0);
        chk("wrap_num2", 32'(com_inst_num_o), 2);
        chk("wrap_tag1", 32'(com_tag1_o), 62);
        chk("wrap_tag2", 32'(com_tag2_o), 63);
        chk("wrap_we1", 32'(arfwe1_o), 1);
        chk("wrap_dst1", 32'(dst_arf1_o), 1);
        chk("wrap_we2", 32'(arfwe2_o), 0);
        tick();
        set_fin(0, 0, 0, 0);
        chk("wrap_comptr0", 32'(comptr_o), 0);
        chk("wrap_num1", 32'(com_inst_num_o), 1);
        chk("wrap_tag1_b", 32'(com_tag1_o), 0);
        chk("wrap_tag2_b", 32'(com_tag2_o), 1);
        chk("wrap_dst1_b", 32'(dst_arf1_o), 3);
        tick();
        chk("wrap_comptr1", 32'(comptr_o), 1);
        chk("wrap_empty_b", 32'(empty_o), 1);

        // Reset with work in flight (tag 1 finished, tag 2 pending)
        set_alloc(1, 1, 7, 1); tick();
        set_alloc(1, 2, 8, 1); set_fin(1, 1, 0, 0); tick();
        set_alloc(0, 0, 0, 0); set_fin(0, 0, 0, 0);
        chk("mid_pre_num", 32'(com_inst_num_o), 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_num", 32'(com_inst_num_o), 0);
        chk("mid_inflight", 32'(inflight_o), 0);
        chk("mid_comptr", 32'(comptr_o), 0);
        chk("mid_empty", 32'(empty_o), 1);
        tick();
        chk("mid_num_b", 32'(com_inst_num_o), 0);

        // Full array, then reuse tag 0 in the cycle it commits
        for (int t = 0; t < 64; t++) begin
            set_alloc(1, t, t, t[0]);
            tick();
        end
        set_alloc(0, 0, 0, 0);
        chk("full_inflight", 32'(inflight_o), 64);
        chk("full_empty", 32'(empty_o), 0);
        chk("full_num", 32'(com_inst_num_o), 0);
        set_fin(1, 0, 1, 1); tick();
        set_fin(0, 0, 0, 0);
        chk("full_num2", 32'(com_inst_num_o), 2);
        chk("full_we1", 32'(arfwe1_o), 0);
        chk("full_we2", 32'(arfwe2_o), 1);
        chk("full_dst2", 32'(dst_arf2_o), 1);
        set_alloc(1, 0, 9, 1); tick();
        set_alloc(0, 0, 0, 0);
        chk("full_inflight63", 32'(inflight_o), 63);
        chk("full_comptr2", 32'(comptr_o), 2);
        for (int k = 0; k < 31; k++) begin
            set_fin(1, 2 + 2 * k, 1, 3 + 2 * k);
            tick();
        end
        set_fin(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            if (inflight_o == 7'd1) break;
            tick();
        end
        chk("reuse_comptr0", 32'(comptr_o), 0);
        chk("reuse_inflight1", 32'(inflight_o), 1);
        chk("reuse_unfinished", 32'(com_inst_num_o), 0);
        set_fin(1, 0, 0, 0); tick();
        set_fin(0, 0, 0, 0);
        chk("reuse_num1", 32'(com_inst_num_o), 1);
        chk("reuse_we1", 32'(arfwe1_o), 1);
        chk("reuse_dst1", 32'(dst_arf1_o), 9);
        tick();
        chk("reuse_comptr1", 32'(comptr_o), 1);
        chk("reuse_empty", 32'(empty_o), 1);

        // Dual finish on the oldest tag
        for (int t = 1; t <= 4; t++) begin
            set_alloc(1, t, t + 10, 1);
            tick();
        end
        set_alloc(0, 0, 0, 0);
        set_fin(1, 1, 1, 2); tick();
        set_fin(1, 3, 0, 0); tick();
        set_fin(0, 0, 0, 0); tick();
        chk("dual_comptr4", 32'(comptr_o), 4);
        chk("dual_inflight1", 32'(inflight_o), 1);
        set_fin(1, 4, 1, 4); tick();
        set_fin(0, 0, 0, 0);
        chk("dual_num1", 32'(com_inst_num_o), 1);
        chk("dual_tag1", 32'(com_tag1_o), 4);
        chk("dual_dst1", 32'(dst_arf1_o), 14);
        chk("dual_we2", 32'(arfwe2_o), 0);
        tick();
        chk("dual_comptr5", 32'(comptr_o), 5);
        chk("dual_empty", 32'(empty_o), 1);

        // Random traffic against an allocator + in-order retire model
        freenum = 64;
        rrfptr  = 6'd5;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  n;
            int  idx;
            logic do_alloc;
            ent_t e;
            n = 0;
            if (q.size() >= 1 && q[0].fin) n = 1;
            if (n == 1 && q.size() >= 2 && q[1].fin) n = 2;
            chk("rnd_num", 32'(com_inst_num_o), n);
            chk("rnd_invariant", 32'(inflight_o) + 32'(freenum), 64);
            chk("rnd_comptr", 32'(comptr_o), int'(6'(rrfptr - 6'(q.size()))));
            if (n >= 1) begin
                chk("rnd_tag1", 32'(com_tag1_o), int'(q[0].tag));
                chk("rnd_we1", 32'(arfwe1_o), int'(q[0].dv));
                if (q[0].dv) chk("rnd_dst1", 32'(dst_arf1_o), int'(q[0].dst));
            end
            if (n == 2) begin
                chk("rnd_tag2", 32'(com_tag2_o), int'(q[1].tag));
                chk("rnd_we2", 32'(arfwe2_o), int'(q[1].dv));
                if (q[1].dv) chk("rnd_dst2", 32'(dst_arf2_o), int'(q[1].dst));
            end

            set_fin(0, 0, 0, 0);
            if (q.size() > n && $urandom_range(0, 2) != 0) begin
                idx = int'($urandom_range(n, q.size() - 1));
                if (!q[idx].fin) begin
                    fin0_valid_i = 1'b1;
                    fin0_tag_i   = q[idx].tag;
                end
            end
            if (q.size() > n && $urandom_range(0, 2) != 0) begin
                idx = int'($urandom_range(n, q.size() - 1));
                if (!q[idx].fin) begin
                    fin1_valid_i = 1'b1;
                    fin1_tag_i   = q[idx].tag;
                end
            end
            for (int i = n; i < q.size(); i++) begin
                if ((fin0_valid_i && q[i].tag == fin0_tag_i) ||
                    (fin1_valid_i && q[i].tag == fin1_tag_i))
                    q[i].fin = 1'b1;
            end

            do_alloc = (freenum + n > 0) && ($urandom_range(0, 3) != 0);
            e.tag = rrfptr;
            e.dst = 5'($urandom);
            e.dv  = 1'($urandom);
            e.fin = 1'b0;
            set_alloc(do_alloc, int'(e.tag), int'(e.dst), e.dv);

            for (int i = 0; i < n; i++) void'(q.pop_front());
            if (do_alloc) begin
                q.push_back(e);
                rrfptr = rrfptr + 6'd1;
            end
            freenum = freenum + n - int'(do_alloc);
            tick();
        end
        set_alloc(0, 0, 0, 0);
        set_fin(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
